dac_control: RTL and testbench

- Serial writer for the dual-channel 12-bit DAC that drives the sensor LED and bias outputs; it is the transmit-side counterpart to the ADC sampling path.
- Accepts a pair of 12-bit codes through a valid/ready handshake.
- Sends two 16-bit frames, channel A then channel B, MSB first on a generated SCLK.
- Pulses LDAC low afterwards so both DAC outputs update together. Runs entirely in the clk_20M domain.

---
 rtl/dac_ctrl_pkg.sv | 18 +
 rtl/dac_control_sclk_tick_gen.sv | 27 ++
 rtl/dac_control.sv | 157 +++++++++++++++
 tb/tb_dac_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the dual-channel DAC serial writer.
package dac_ctrl_pkg;

   localparam int FRAME_W = 16;
   localparam int CODE_W  = 12;

   localparam logic [1:0] ADDR_A = 2'b00;
   localparam logic [1:0] ADDR_B = 2'b01;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;

   function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0]        addr,
                                                     input logic [1:0]        ctrl,
                                                     input logic [CODE_W-1:0] code);
      return {addr, ctrl, code};
   endfunction

endpackage

// File: rtl/dac_control_sclk_tick_gen.sv
// Half-period tick source for SCLK: one-cycle pulse every HALF_DIV enabled clocks.
module sclk_tick_gen #(
   parameter int HALF_DIV = 1
) (
   input  logic clk_20M,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_20M) begin
      if (!reset_n || clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   // Combinational so the first tick lands exactly HALF_DIV clocks after leaving IDLE.
   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/dac_control.sv
// Serial writer for the dual-channel 12-bit DAC: frame A, gap, frame B, then an LDAC pulse.
module dac_control
   import dac_ctrl_pkg::*;
#(
   parameter int         HALF_DIV  = 1,
   parameter int         GAP_HALF  = 4,
   parameter int         LDAC_HALF = 2,
   parameter logic [1:0] CTRL_BITS = 2'b01
) (
   input  logic              clk_20M,
   input  logic              reset_n,
   input  logic [CODE_W-1:0] pdata1,
   input  logic [CODE_W-1:0] pdata2,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              busy,
   output logic              dac_sclk,
   output logic              dac_sync_n,
   output logic              dac_din,
   output logic              dac_ldac_n
);

   localparam logic [7:0] GAP_LAST  = 8'(GAP_HALF - 1);
   localparam logic [7:0] LDAC_LAST = 8'(LDAC_HALF - 1);

   state_t              state, state_nxt;
   logic [3:0]          bit_cnt, bit_nxt;
   logic [7:0]          half_cnt, half_nxt;
   logic                frame_b, frame_b_nxt;
   logic [CODE_W-1:0]   code_a, code_a_nxt, code_b, code_b_nxt;
   logic                ready_nxt, busy_nxt, sclk_nxt, sync_nxt, din_nxt, ldac_nxt;
   logic                tick;
   logic [FRAME_W-1:0]  cur_frame;
   logic [3:0]          nxt_idx;

   sclk_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
      .clk_20M (clk_20M),
      .reset_n (reset_n),
      .en      (state != IDLE),
      .clr     (state == IDLE),
      .tick    (tick)
   );

   assign cur_frame = frame_b ? make_frame(ADDR_B, CTRL_BITS, code_b)
                              : make_frame(ADDR_A, CTRL_BITS, code_a);
   assign nxt_idx   = 4'd14 - bit_cnt;

   always_ff @(posedge clk_20M) begin
      if (!reset_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         half_cnt   <= '0;
         frame_b    <= 1'b0;
         code_a     <= '0;
         code_b     <= '0;
         load_ready <= 1'b0;
         busy       <= 1'b0;
         dac_sclk   <= 1'b1;
         dac_sync_n <= 1'b1;
         dac_din    <= 1'b0;
         dac_ldac_n <= 1'b1;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_nxt;
         half_cnt   <= half_nxt;
         frame_b    <= frame_b_nxt;
         code_a     <= code_a_nxt;
         code_b     <= code_b_nxt;
         load_ready <= ready_nxt;
         busy       <= busy_nxt;
         dac_sclk   <= sclk_nxt;
         dac_sync_n <= sync_nxt;
         dac_din    <= din_nxt;
         dac_ldac_n <= ldac_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_nxt     = bit_cnt;
      half_nxt    = half_cnt;
      frame_b_nxt = frame_b;
      code_a_nxt  = code_a;
      code_b_nxt  = code_b;
      ready_nxt   = load_ready;
      busy_nxt    = busy;
      sclk_nxt    = dac_sclk;
      sync_nxt    = dac_sync_n;
      din_nxt     = dac_din;
      ldac_nxt    = dac_ldac_n;

      case (state)
         IDLE: begin
            if (load_valid && load_ready) begin
               code_a_nxt  = pdata1;
               code_b_nxt  = pdata2;
               ready_nxt   = 1'b0;
               busy_nxt    = 1'b1;
               sync_nxt    = 1'b0;
               din_nxt     = ADDR_A[1];
               bit_nxt     = '0;
               frame_b_nxt = 1'b0;
               state_nxt   = SHIFT;
            end else begin
               ready_nxt = 1'b1;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (dac_sclk) begin
                  sclk_nxt = 1'b0;
               end else begin
                  sclk_nxt = 1'b1;
                  if (bit_cnt == 4'd15) begin
                     sync_nxt  = 1'b1;
                     half_nxt  = '0;
                     state_nxt = frame_b ? LDAC : GAP;
                     if (frame_b) ldac_nxt = 1'b0;
                  end else begin
                     bit_nxt = bit_cnt + 4'd1;
                     din_nxt = cur_frame[nxt_idx];
                  end
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (half_cnt == GAP_LAST) begin
                  sync_nxt    = 1'b0;
                  din_nxt     = ADDR_B[1];
                  bit_nxt     = '0;
                  half_nxt    = '0;
                  frame_b_nxt = 1'b1;
                  state_nxt   = SHIFT;
               end else begin
                  half_nxt = half_cnt + 8'd1;
               end
            end
         end
         LDAC: begin
            if (tick) begin
               if (half_cnt == LDAC_LAST) begin
                  ldac_nxt  = 1'b1;
                  ready_nxt = 1'b1;
                  busy_nxt  = 1'b0;
                  half_nxt  = '0;
                  state_nxt = IDLE;
               end else begin
                  half_nxt = half_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dac_control.sv
// Bench for dac_control: default instance plus a HALF_DIV=3 instance, checked against frame/timing rules.
module tb_dac_control;

   typedef struct {int fr; int acc; int ldac; int rdy;} base_t;

   logic clk = 1'b0;
   always #25 clk = ~clk;

   logic        reset_n;
   logic [11:0] pd1 [2];
   logic [11:0] pd2 [2];
   logic        lv [2];
   logic        ready [2], busy [2], sclk [2], sync_n [2], din [2], ldac [2];

   int vec  = 0;
   int miss = 0;
   int cyc  = 0;

   dac_control u0 (
      .clk_20M(clk), .reset_n(reset_n), .pdata1(pd1[0]), .pdata2(pd2[0]),
      .load_valid(lv[0]), .load_ready(ready[0]), .busy(busy[0]), .dac_sclk(sclk[0]),
      .dac_sync_n(sync_n[0]), .dac_din(din[0]), .dac_ldac_n(ldac[0]));

   dac_control #(.HALF_DIV(3)) u1 (
      .clk_20M(clk), .reset_n(reset_n), .pdata1(pd1[1]), .pdata2(pd2[1]),
      .load_valid(lv[1]), .load_ready(ready[1]), .busy(busy[1]), .dac_sclk(sclk[1]),
      .dac_sync_n(sync_n[1]), .dac_din(din[1]), .dac_ldac_n(ldac[1]));

   // Bus monitor: reconstructs frames from falling SCLK edges and logs event cycles.
   int          fr_n [2], acc_n [2], ldac_cnt [2], rdy_n [2], stray [2], cur_bits [2];
   logic [15:0] cur_word [2];
   logic [15:0] fr_word [2][64];
   int          fr_bits [2][64], fr_fall [2][64], fr_rise [2][64];
   int          acc_cyc [2][64], ldac_fall [2][64], ldac_rise [2][64], rdy_rise [2][64];
   logic        p_sclk [2]  = '{1'b1, 1'b1};
   logic        p_sync [2]  = '{1'b1, 1'b1};
   logic        p_ldac [2]  = '{1'b1, 1'b1};
   logic        p_ready [2] = '{1'b0, 1'b0};
   logic        p_busy [2]  = '{1'b0, 1'b0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         if (p_sync[g] === 1'b1 && sync_n[g] === 1'b0) begin
            cur_word[g] = '0;
            cur_bits[g] = 0;
            fr_fall[g][fr_n[g] % 64] = cyc;
         end
         if (sync_n[g] === 1'b0 && p_sclk[g] === 1'b1 && sclk[g] === 1'b0) begin
            cur_word[g] = {cur_word[g][14:0], din[g]};
            cur_bits[g]++;
         end
         if (p_sync[g] === 1'b1 && sync_n[g] === 1'b1 && sclk[g] !== p_sclk[g]) stray[g]++;
         if (p_sync[g] === 1'b0 && sync_n[g] === 1'b1) begin
            fr_word[g][fr_n[g] % 64] = cur_word[g];
            fr_bits[g][fr_n[g] % 64] = cur_bits[g];
            fr_rise[g][fr_n[g] % 64] = cyc;
            fr_n[g]++;
         end
         if (p_ldac[g] === 1'b1 && ldac[g] === 1'b0) ldac_fall[g][ldac_cnt[g] % 64] = cyc;
         if (p_ldac[g] === 1'b0 && ldac[g] === 1'b1) begin
            ldac_rise[g][ldac_cnt[g] % 64] = cyc;
            ldac_cnt[g]++;
         end
         if (p_busy[g] === 1'b0 && busy[g] === 1'b1) begin
            acc_cyc[g][acc_n[g] % 64] = cyc;
            acc_n[g]++;
         end
         if (p_ready[g] === 1'b0 && ready[g] === 1'b1) begin
            rdy_rise[g][rdy_n[g] % 64] = cyc;
            rdy_n[g]++;
         end
         p_sclk[g]  = sclk[g];
         p_sync[g]  = sync_n[g];
         p_ldac[g]  = ldac[g];
         p_ready[g] = ready[g];
         p_busy[g]  = busy[g];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic base_t snap(input int g);
      base_t b;
      b.fr   = fr_n[g];
      b.acc  = acc_n[g];
      b.ldac = ldac_cnt[g];
      b.rdy  = rdy_n[g];
      return b;
   endfunction

   task automatic start(input int g, input logic [11:0] a, input logic [11:0] b,
                        input bit hold, output base_t bs);
      int to = 0;
      @(negedge clk);
      while (ready[g] !== 1'b1 && to < 3000) begin @(negedge clk); to++; end
      chk("ready_wait", 32'(to < 3000), 32'd1);
      bs = snap(g);
      pd1[g] = a; pd2[g] = b; lv[g] = 1'b1;
      @(negedge clk);
      if (!hold) lv[g] = 1'b0;
   endtask

   // Expected frames are {address, control, code}; timing follows the per-frame half-period counts.
   task automatic check_txn(input int g, input logic [11:0] a, input logic [11:0] b, input base_t bs);
      int h  = (g == 0) ? 1 : 3;
      int to = 0;
      int fa, fb, ac, lc, rc;
      while (!(fr_n[g] >= bs.fr + 2 && rdy_n[g] >= bs.rdy + 1 && ldac_cnt[g] >= bs.ldac + 1)
             && to < 3000) begin
         @(negedge clk); to++;
      end
      chk("txn_timeout", 32'(to < 3000), 32'd1);
      fa = bs.fr % 64; fb = (bs.fr + 1) % 64; ac = bs.acc % 64;
      lc = bs.ldac % 64; rc = bs.rdy % 64;
      chk("frame_a",   32'(fr_word[g][fa]), {16'd0, 2'b00, 2'b01, a});
      chk("bits_a",    32'(fr_bits[g][fa]), 32'd16);
      chk("frame_b",   32'(fr_word[g][fb]), {16'd0, 2'b01, 2'b01, b});
      chk("bits_b",    32'(fr_bits[g][fb]), 32'd16);
      chk("sync_at_accept", 32'(fr_fall[g][fa]), 32'(acc_cyc[g][ac]));
      chk("sync_low_a", 32'(fr_rise[g][fa] - fr_fall[g][fa]), 32'(32 * h));
      chk("gap_len",    32'(fr_fall[g][fb] - fr_rise[g][fa]), 32'(4 * h));
      chk("sync_low_b", 32'(fr_rise[g][fb] - fr_fall[g][fb]), 32'(32 * h));
      chk("ldac_start", 32'(ldac_fall[g][lc] - acc_cyc[g][ac]), 32'(68 * h));
      chk("ldac_len",   32'(ldac_rise[g][lc] - ldac_fall[g][lc]), 32'(2 * h));
      chk("txn_len",    32'(rdy_rise[g][rc] - acc_cyc[g][ac]), 32'(70 * h));
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      base_t bs, bs2;
      logic [11:0] a, b;
      int to, lc;

      reset_n = 1'b0;
      lv[0] = 1'b1; lv[1] = 1'b0;
      pd1[0] = 12'hA5C; pd2[0] = 12'h3F0;
      pd1[1] = 12'h000; pd2[1] = 12'h000;
      repeat (3) @(negedge clk);
      chk("rst_sclk",  32'(sclk[0]),   32'd1);
      chk("rst_sync",  32'(sync_n[0]), 32'd1);
      chk("rst_din",   32'(din[0]),    32'd0);
      chk("rst_ldac",  32'(ldac[0]),   32'd1);
      chk("rst_ready", 32'(ready[0]),  32'd0);
      chk("rst_busy",  32'(busy[0]),   32'd0);
      chk("rst_ready1", 32'(ready[1]), 32'd0);

      // Release with valid already high: ready first, accept only on the following edge.
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_ready", 32'(ready[0]),  32'd1);
      chk("rel_busy",  32'(busy[0]),   32'd0);
      chk("rel_sync",  32'(sync_n[0]), 32'd1);
      bs = snap(0);
      @(posedge clk); #1;
      chk("acc_busy",  32'(busy[0]),   32'd1);
      chk("acc_ready", 32'(ready[0]),  32'd0);
      chk("acc_din",   32'(din[0]),    32'd0);
      @(negedge clk); lv[0] = 1'b0;
      check_txn(0, 12'hA5C, 12'h3F0, bs);

      start(0, 12'h000, 12'hFFF, 1'b0, bs);
      check_txn(0, 12'h000, 12'hFFF, bs);

      // Valid held high with inputs churning while busy.
      start(0, 12'h123, 12'hDEF, 1'b1, bs);
      to = 0;
      while (ready[0] !== 1'b1 && to < 3000) begin
         pd1[0] = 12'($urandom); pd2[0] = 12'($urandom);
         @(negedge clk); to++;
      end
      chk("hold_wait", 32'(to < 3000), 32'd1);
      bs2 = snap(0);
      pd1[0] = 12'h9B7; pd2[0] = 12'h4C1;
      @(negedge clk); lv[0] = 1'b0;
      check_txn(0, 12'h123, 12'hDEF, bs);
      check_txn(0, 12'h9B7, 12'h4C1, bs2);
      chk("b2b_spacing", 32'(acc_cyc[0][bs2.acc % 64] - acc_cyc[0][bs.acc % 64]), 32'd71);

      for (int i = 0; i < 4; i++) begin
         a = 12'($urandom); b = 12'($urandom);
         start(0, a, b, 1'b0, bs);
         check_txn(0, a, b, bs);
      end

      start(1, 12'hA5C, 12'h3F0, 1'b0, bs);
      check_txn(1, 12'hA5C, 12'h3F0, bs);
      for (int i = 0; i < 2; i++) begin
         a = 12'($urandom); b = 12'($urandom);
         start(1, a, b, 1'b0, bs);
         check_txn(1, a, b, bs);
      end

      // Reset in the middle of frame B.
      start(0, 12'h5A5, 12'h7E3, 1'b0, bs);
      to = 0;
      while (!(fr_n[0] >= bs.fr + 1 && sync_n[0] === 1'b0 && cur_bits[0] == 8) && to < 3000) begin
         @(negedge clk); to++;
      end
      chk("mid_wait", 32'(to < 3000), 32'd1);
      lc = ldac_cnt[0];
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_sync",  32'(sync_n[0]), 32'd1);
      chk("mid_sclk",  32'(sclk[0]),   32'd1);
      chk("mid_ldac",  32'(ldac[0]),   32'd1);
      chk("mid_ready", 32'(ready[0]),  32'd0);
      chk("mid_busy",  32'(busy[0]),   32'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_rel_ready", 32'(ready[0]), 32'd1);
      chk("mid_frame_a", 32'(fr_word[0][bs.fr % 64]), {16'd0, 2'b00, 2'b01, 12'h5A5});
      chk("mid_partial_bits", 32'(fr_bits[0][(bs.fr + 1) % 64]), 32'd8);
      repeat (100) @(negedge clk);
      chk("mid_no_ldac", 32'(ldac_cnt[0]), 32'(lc));
      a = 12'($urandom); b = 12'($urandom);
      start(0, a, b, 1'b0, bs);
      check_txn(0, a, b, bs);

      chk("stray_sclk0", 32'(stray[0]), 32'd0);
      chk("stray_sclk1", 32'(stray[1]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
